// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the shared multi-cycle memory port to IF or MEM, one access at a time; MEM_ARB_RR_EN enables round-robin arbitration.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);
  state_t state;
  logic [3:0] cnt;
  logic last_grant;
  logic grant_mem;
  assign grant_mem = mem_req & (~if_req | ~RR | ~last_grant);
  assign stall_if = if_req & ~if_ready;
  assign stall_mem = mem_req & ~mem_ready;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      if_rdata <= '0;
      mem_rdata <= '0;
      if_ready <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      mem_ready <= 1'b0;
      if (state == IDLE) begin
        if (if_req | mem_req) begin
          state <= grant_mem ? BUSY_MEM : BUSY_IF;
          cnt <= '0;
          ram_en <= 1'b1;
          ram_we <= grant_mem & mem_we;
          ram_addr <= grant_mem ? mem_addr : if_addr;
          if (grant_mem) ram_wdata <= mem_wdata;
        end
      end else begin
        cnt <= cnt + 4'd1;
        if (cnt == CNT_LAST) begin
          state <= IDLE;
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          last_grant <= state == BUSY_MEM;
          if (state == BUSY_IF) begin
            if_rdata <= ram_rdata;
            if_ready <= 1'b1;
          end else begin
            mem_ready <= 1'b1;
            if (!ram_we) mem_rdata <= ram_rdata;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized IF/MEM requesters against a transaction-level model with a queue scoreboard.
module tb_mem_port_arbiter;
  localparam int L = 3;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic if_ready, mem_ready, stall_if, stall_mem, ram_en, ram_we;
  int checks = 0, errors = 0;
  logic [31:0] ram [128];
  logic [31:0] refm [128];
  logic [31:0] ifq[$], memq[$];
  logic [31:0] if_cur = '0, m_cur = '0, m_wd = '0, last_load = '0;
  logic m_w = 1'b0;
  int busy_kind = 0;
  bit mon_on = 0, tb_last = 0, stop = 0;

  mem_port_arbiter #(.MEM_LATENCY(L)) dut (
    .CLK(CLK), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] h(int i);
    return (i * 32'h9E3779B1) ^ 32'h8C010004;
  endfunction

  always @(posedge CLK) begin
    if (RESET) for (int i = 0; i < 128; i++) ram[i] <= h(i);
    else if (ram_en && ram_we) ram[ram_addr[8:2]] <= ram_wdata;
  end
  assign ram_rdata = ram[ram_addr[8:2]];

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic new_if();
    if_cur = 32'($urandom_range(0, 63)) << 2;
    if_req = 1'b1;
    if_addr = if_cur;
    ifq.push_back(refm[if_cur[8:2]]);
  endtask

  task automatic new_mem();
    int idx = 64 + $urandom_range(0, 31);
    m_cur = 32'(idx) << 2;
    m_w = 1'($urandom_range(0, 1));
    m_wd = $urandom;
    mem_req = 1'b1;
    mem_we = m_w;
    mem_addr = m_cur;
    mem_wdata = m_wd;
    if (m_w) refm[idx] = m_wd;
    else last_load = refm[idx];
    memq.push_back(last_load);
  endtask

  // monitor: pops the scoreboard on each ready pulse and checks port behaviour
  initial begin
    int run = 0, wait_cyc = 0;
    logic p_en = 1'b0;
    logic exp_mem;
    forever begin
      @(posedge CLK);
      #1;
      if (mon_on) begin
        chk("stall_if", stall_if, if_req & ~if_ready);
        chk("stall_mem", stall_mem, mem_req & ~mem_ready);
        chk("ready_excl", if_ready & mem_ready, 0);
        if (ram_en && !p_en) begin
          exp_mem = mem_req && (!if_req || !RR || !tb_last);
          busy_kind = exp_mem ? 2 : 1;
          chk("grant_we", ram_we, exp_mem & m_w);
          if (exp_mem && m_w) chk("grant_wdata", ram_wdata, m_wd);
        end
        if (ram_en) begin
          run++;
          chk("busy_addr", ram_addr, busy_kind == 2 ? m_cur : if_cur);
        end
        if (if_ready || mem_ready) begin
          chk("latency", run, L);
          chk("ready_en", ram_en, 0);
          chk("ready_kind", mem_ready, busy_kind == 2);
          run = 0;
          wait_cyc = 0;
          tb_last = mem_ready;
          if (if_ready) begin
            if (ifq.size() == 0) begin
              errors++;
              $display("FAIL if_ready unexpected got 1 want 0");
            end else chk("if_rdata", if_rdata, ifq.pop_front());
          end
          if (mem_ready) begin
            if (memq.size() == 0) begin
              errors++;
              $display("FAIL mem_ready unexpected got 1 want 0");
            end else chk("mem_rdata", mem_rdata, memq.pop_front());
          end
        end else if (if_req || mem_req) begin
          wait_cyc++;
          if (wait_cyc > 3 * (L + 1)) begin
            errors++;
            $display("FAIL timeout got %0d cycles want <= %0d", wait_cyc, 3 * (L + 1));
            wait_cyc = 0;
          end
        end
        p_en = ram_en;
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) refm[i] = h(i);
    repeat (2) @(negedge CLK);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_readys", {if_ready, mem_ready}, 0);
    RESET = 1'b0;
    mem_req = 1'b1;
    mem_we = 1'b1;
    mem_addr = 32'h100;
    mem_wdata = 32'hDEADBEEF;
    @(negedge CLK);
    chk("st_ram_en", ram_en, 1);
    chk("st_ram_we", ram_we, 1);
    chk("st_ram_addr", ram_addr, 32'h100);
    chk("st_ram_wdata", ram_wdata, 32'hDEADBEEF);
    chk("st_stall_mem", stall_mem, 1);
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("arst_ram_en", ram_en, 0);
    chk("arst_ram_we", ram_we, 0);
    chk("arst_ram_addr", ram_addr, 0);
    chk("arst_ram_wdata", ram_wdata, 0);
    mem_req = 1'b0;
    mem_we = 1'b0;
    #1 chk("arst_stall_mem", stall_mem, 0);
    @(negedge CLK);
    RESET = 1'b0;
    refm[64] = 32'hDEADBEEF;
    repeat (4) begin
      @(negedge CLK);
      chk("arst_no_ready", mem_ready, 0);
    end
    last_load = '0;
    tb_last = 0;
    mon_on = 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge CLK);
      stop = cyc > 1800;
      if (if_req) begin
        if (if_ready) begin
          if (!stop && $urandom_range(0, 3) != 0) new_if();
          else if_req = 1'b0;
        end else if (ram_en && busy_kind == 1) if_addr = $urandom;
      end else if (!stop && $urandom_range(0, 2) == 0) new_if();
      if (mem_req) begin
        if (mem_ready) begin
          if (!stop && $urandom_range(0, 3) != 0) new_mem();
          else mem_req = 1'b0;
        end else if (ram_en && busy_kind == 2) begin
          mem_addr = $urandom;
          mem_wdata = $urandom;
        end
      end else if (!stop && $urandom_range(0, 2) == 0) new_mem();
    end
    chk("if_drained", ifq.size(), 0);
    chk("mem_drained", memq.size(), 0);
    chk("reqs_drained", {if_req, mem_req}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
